// File: rtl/shift_ex_stage.sv
// Two-stage 16-bit execute shift unit: S1 operand capture, then barrel shifter into a registered result.
// Optional SHIFT_EX_FWD_EN forwards the retiring result into a dependent op in S1.
module shift_ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [15:0] in_src,
  input  logic [15:0] in_rt,
  input  logic [3:0]  in_imm,
  input  logic        in_use_imm,
  input  logic [2:0]  in_rs,
  input  logic [2:0]  in_wr_reg,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_result,
  output logic [2:0]  out_wr_reg
);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_SHL = 2'b01,
    OP_ROR = 2'b10,
    OP_SRL = 2'b11
  } op_e;

  logic        r_s1_valid;
  op_e         r_s1_op;
  logic [15:0] r_s1_src;
  logic [3:0]  r_s1_cnt;
  logic [2:0]  r_s1_wr_reg;

  logic        r_out_valid;
  logic [15:0] r_out_result;
  logic [2:0]  r_out_wr_reg;

  logic        w_s1_advance;
  logic        w_accept;
  logic [3:0]  w_in_cnt;
  logic [15:0] w_shift_src;
  logic [15:0] w_lvl1, w_lvl2, w_lvl4, w_lvl8;

  // in_ready depends combinationally on out_ready: a full S1 frees up in the same cycle it advances.
  assign w_s1_advance = r_s1_valid & (~r_out_valid | out_ready);
  assign in_ready     = ~r_s1_valid | w_s1_advance;
  assign w_accept     = in_valid & in_ready & ~flush;
  assign w_in_cnt     = in_use_imm ? in_imm : in_rt[3:0];

`ifdef SHIFT_EX_FWD_EN
  logic [2:0] r_s1_rs;
  logic       w_fwd;
  logic       w_unused;

  assign w_unused    = &{1'b0, in_rt[15:4]};
  // Only matters when S1 advances, which is exactly when the OR contents are being retired.
  assign w_fwd       = r_out_valid & out_ready & (r_s1_rs == r_out_wr_reg);
  assign w_shift_src = w_fwd ? r_out_result : r_s1_src;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_s1_rs <= '0;
    else if (w_accept) r_s1_rs <= in_rs;
  end
`else
  logic w_unused;

  assign w_unused    = &{1'b0, in_rt[15:4], in_rs};
  assign w_shift_src = r_s1_src;
`endif

  // One barrel level: shift/rotate by a fixed power-of-two amount when enabled.
  function automatic logic [15:0] shift_level(input logic [15:0] d, input op_e op,
                                              input logic en, input int unsigned amt);
    logic [15:0] r;
    r = d;
    if (en) begin
      case (op)
        OP_ROL: r = (d << amt) | (d >> (16 - amt));
        OP_SHL: r = d << amt;
        OP_ROR: r = (d >> amt) | (d << (16 - amt));
        OP_SRL: r = d >> amt;
      endcase
    end
    return r;
  endfunction

  assign w_lvl1 = shift_level(w_shift_src, r_s1_op, r_s1_cnt[0], 1);
  assign w_lvl2 = shift_level(w_lvl1,      r_s1_op, r_s1_cnt[1], 2);
  assign w_lvl4 = shift_level(w_lvl2,      r_s1_op, r_s1_cnt[2], 4);
  assign w_lvl8 = shift_level(w_lvl4,      r_s1_op, r_s1_cnt[3], 8);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_op     <= OP_ROL;
      r_s1_src    <= '0;
      r_s1_cnt    <= '0;
      r_s1_wr_reg <= '0;
    end else begin
      if (w_accept) begin
        r_s1_valid  <= 1'b1;
        r_s1_op     <= op_e'(in_op);
        r_s1_src    <= in_src;
        r_s1_cnt    <= w_in_cnt;
        r_s1_wr_reg <= in_wr_reg;
      end else if (w_s1_advance || flush) begin
        r_s1_valid  <= 1'b0;
      end
    end
  end

  // The output register is never flushed: its op is older than anything flush targets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_wr_reg <= '0;
    end else if (w_s1_advance) begin
      r_out_valid  <= 1'b1;
      r_out_result <= w_lvl8;
      r_out_wr_reg <= r_s1_wr_reg;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_wr_reg = r_out_wr_reg;

endmodule

// File: tb/tb_shift_ex_stage.sv
// Self-checking bench for shift_ex_stage: directed scenarios plus a randomized stream
// checked against an arithmetic shift model and an in-order scoreboard.
module tb_shift_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [15:0] in_src;
  logic [15:0] in_rt;
  logic [3:0]  in_imm;
  logic        in_use_imm;
  logic [2:0]  in_rs;
  logic [2:0]  in_wr_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_wr_reg;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [15:0] res;
    logic [2:0]  wr;
  } exp_t;

  exp_t sb[$];

  shift_ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_src     (in_src),
    .in_rt      (in_rt),
    .in_imm     (in_imm),
    .in_use_imm (in_use_imm),
    .in_rs      (in_rs),
    .in_wr_reg  (in_wr_reg),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_wr_reg (out_wr_reg)
  );

  always #5 clk = ~clk;

  // Reference: rotates via a doubled word, shifts via multiply/divide by 2^n.
  function automatic logic [15:0] ref_shift(input logic [1:0] op, input logic [15:0] src,
                                            input int n);
    logic [31:0] dbl;
    logic [31:0] t;
    dbl = {src, src};
    case (op)
      2'b00:   begin t = dbl << n;                  return t[31:16]; end
      2'b01:   begin t = {16'h0, src} * (32'd1 << n); return t[15:0]; end
      2'b10:   begin t = dbl >> n;                  return t[15:0];  end
      default: begin t = {16'h0, src} / (32'd1 << n); return t[15:0]; end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [15:0] src, input logic [15:0] rt,
                          input logic [3:0] imm, input logic use_imm, input logic [2:0] rs,
                          input logic [2:0] wr);
    in_valid   = 1'b1;
    in_op      = op;
    in_src     = src;
    in_rt      = rt;
    in_imm     = imm;
    in_use_imm = use_imm;
    in_rs      = rs;
    in_wr_reg  = wr;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  // Waits (bounded) for a valid result with out_ready high and consumes it.
  task automatic pop_output(output logic [15:0] res, output logic [2:0] wr, output bit ok);
    ok  = 1'b0;
    res = 'x;
    wr  = 'x;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        res = out_result;
        wr  = out_wr_reg;
        ok  = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    idle();
    out_ready = 1'b1;
    drive_op(2'b00, 16'h0, 16'h0, 4'h0, 1'b0, 3'd0, 3'd0);
    in_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    vectors++;
    if (out_result !== 16'h0000) begin
      miscompares++; $display("FAIL reset_out_result: got %h expected 0000", out_result);
    end
    vectors++;
    if (out_wr_reg !== 3'd0) begin
      miscompares++; $display("FAIL reset_out_wr_reg: got %0d expected 0", out_wr_reg);
    end
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tick();
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    drive_op(2'b00, 16'h8001, 16'h0, 4'd1, 1'b1, 3'd0, 3'd6);
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_early: out_valid got %b expected 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 16'h0003 || out_wr_reg !== 3'd6) begin
      miscompares++;
      $display("FAIL latency_result: got v=%b %h r%0d expected v=1 0003 r6",
               out_valid, out_result, out_wr_reg);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL latency_one_cycle: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_op_sweep();
    logic [1:0]  ops [9] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
    logic [15:0] srcs[9] = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234,
                             16'h8000, 16'h8001, 16'hABCD, 16'hABCD};
    logic [15:0] rts [9] = '{16'h0004, 16'h0004, 16'h0004, 16'h0004, 16'hA5A8,
                             16'hFFF0, 16'h0003, 16'h0007, 16'h000F};
    logic [3:0]  imms[9] = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd3, 4'd15, 4'd15, 4'd0, 4'd0};
    logic        useq[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [15:0] exps[9] = '{16'h2341, 16'h2340, 16'h4123, 16'h0123, 16'h3412,
                             16'h0001, 16'h8000, 16'hABCD, 16'hABCD};
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_op(ops[i], srcs[i], rts[i], imms[i], useq[i], 3'd0, 3'(i));
      tick();
      idle();
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_result !== exps[i] || out_wr_reg !== 3'(i)) begin
        miscompares++;
        $display("FAIL op_sweep[%0d]: got v=%b %h r%0d expected v=1 %h r%0d",
                 i, out_valid, out_result, out_wr_reg, exps[i], 3'(i));
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] srcs[4] = '{16'h0101, 16'h0F00, 16'h8421, 16'hC003};
    logic [15:0] res;
    logic [2:0]  wr;
    logic [15:0] held;
    bit ok;
    int accepted = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (accepted < 4) drive_op(2'b01, srcs[accepted], 16'h0, 4'd2, 1'b1, 3'd0, 3'(accepted));
      #1;
      if (in_valid && in_ready) accepted++;
      tick();
    end
    vectors++;
    if (accepted !== 2 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: accepted %0d in_ready %b expected 2 and 0", accepted, in_ready);
    end
    held = out_result;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== ref_shift(2'b01, srcs[0], 2)) begin
      miscompares++;
      $display("FAIL bp_hold: got v=%b %h (prev %h) expected v=1 %h",
               out_valid, out_result, held, ref_shift(2'b01, srcs[0], 2));
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      res = 'x;
      wr = 'x;
      for (int c = 0; c < 20 && !ok; c++) begin
        if (accepted < 4) drive_op(2'b01, srcs[accepted], 16'h0, 4'd2, 1'b1, 3'd0, 3'(accepted));
        else in_valid = 1'b0;
        #1;
        if (out_valid) begin
          res = out_result; wr = out_wr_reg; ok = 1'b1;
        end
        if (in_valid && in_ready) accepted++;
        tick();
      end
      vectors++;
      if (!ok || res !== ref_shift(2'b01, srcs[k], 2) || wr !== 3'(k)) begin
        miscompares++;
        $display("FAIL bp_order[%0d]: got ok=%b %h r%0d expected %h r%0d",
                 k, ok, res, wr, ref_shift(2'b01, srcs[k], 2), 3'(k));
      end
    end
    idle();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL bp_no_dup: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    logic [15:0] res;
    logic [2:0]  wr;
    bit ok;
    int extra = 0;
    // Case 1: S1 full, OR stalled; flush drops S1 and the offered input.
    out_ready = 1'b0;
    drive_op(2'b11, 16'hF0F0, 16'h0, 4'd4, 1'b1, 3'd0, 3'd1);
    tick();
    drive_op(2'b01, 16'h00FF, 16'h0, 4'd4, 1'b1, 3'd0, 3'd2);
    tick();
    drive_op(2'b00, 16'h1111, 16'h0, 4'd1, 1'b1, 3'd0, 3'd3);
    flush = 1'b1;
    tick();
    idle();
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 16'h0F0F || out_wr_reg !== 3'd1) begin
      miscompares++;
      $display("FAIL flush_or_kept: got v=%b %h r%0d expected v=1 0f0f r1",
               out_valid, out_result, out_wr_reg);
    end
    out_ready = 1'b1;
    pop_output(res, wr, ok);
    vectors++;
    if (!ok || res !== 16'h0F0F || wr !== 3'd1) begin
      miscompares++; $display("FAIL flush_or_drain: got ok=%b %h r%0d expected 0f0f r1", ok, res, wr);
    end
    for (int c = 0; c < 4; c++) begin
      if (out_valid) extra++;
      tick();
    end
    vectors++;
    if (extra !== 0) begin
      miscompares++; $display("FAIL flush_squashed: %0d extra results expected 0", extra);
    end
    // Case 2: flush blocks an accept into an empty stage.
    drive_op(2'b01, 16'h0001, 16'h0, 4'd1, 1'b1, 3'd0, 3'd4);
    flush = 1'b1;
    tick();
    idle();
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_blocks_accept: out_valid got %b expected 0", out_valid);
    end
    // Case 3: flush coinciding with an S1 advance lets the S1 op through.
    drive_op(2'b10, 16'h00F1, 16'h0, 4'd4, 1'b1, 3'd0, 3'd5);
    tick();
    drive_op(2'b01, 16'h7777, 16'h0, 4'd1, 1'b1, 3'd0, 3'd6);
    flush = 1'b1;
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 16'h100F || out_wr_reg !== 3'd5) begin
      miscompares++;
      $display("FAIL flush_with_advance: got v=%b %h r%0d expected v=1 100f r5",
               out_valid, out_result, out_wr_reg);
    end
    tick();
    tick();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_input_dropped: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_forward();
    logic [15:0] exp_b;
`ifdef SHIFT_EX_FWD_EN
    exp_b = 16'h0004;
`else
    exp_b = 16'hFFFE;
`endif
    out_ready = 1'b1;
    drive_op(2'b01, 16'h0001, 16'h0, 4'd1, 1'b1, 3'd0, 3'd3);
    tick();
    drive_op(2'b01, 16'hFFFF, 16'h0, 4'd1, 1'b1, 3'd3, 3'd5);
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 16'h0002 || out_wr_reg !== 3'd3) begin
      miscompares++;
      $display("FAIL fwd_a: got v=%b %h r%0d expected v=1 0002 r3", out_valid, out_result, out_wr_reg);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== exp_b || out_wr_reg !== 3'd5) begin
      miscompares++;
      $display("FAIL fwd_b: got v=%b %h r%0d expected v=1 %h r5",
               out_valid, out_result, out_wr_reg, exp_b);
    end
    tick();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [15:0] src, rt;
    logic [3:0]  imm;
    logic        use_imm;
    exp_t        e;
    out_ready = 1'b1;
    sb.delete();
    for (int c = 0; c < 400; c++) begin
      op      = 2'($urandom);
      src     = 16'($urandom);
      rt      = 16'($urandom);
      imm     = 4'($urandom);
      use_imm = 1'($urandom);
      drive_op(op, src, rt, imm, use_imm, 3'(4 + $urandom_range(0, 3)), 3'($urandom_range(0, 3)));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      vectors++;
      if (in_ready !== ((sb.size() < 2) || out_ready)) begin
        miscompares++;
        $display("FAIL rand_in_ready[%0d]: got %b expected %b (inflight %0d)",
                 c, in_ready, (sb.size() < 2) || out_ready, sb.size());
      end
      if (out_valid && out_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++; $display("FAIL rand_spurious[%0d]: got %h with nothing in flight", c, out_result);
        end else begin
          e = sb.pop_front();
          if (out_result !== e.res || out_wr_reg !== e.wr) begin
            miscompares++;
            $display("FAIL rand_result[%0d]: got %h r%0d expected %h r%0d",
                     c, out_result, out_wr_reg, e.res, e.wr);
          end
        end
      end
      if (in_valid && in_ready) begin
        e.res = ref_shift(op, src, int'(use_imm ? imm : rt[3:0]));
        e.wr  = in_wr_reg;
        sb.push_back(e);
      end
      tick();
    end
    idle();
    out_ready = 1'b1;
    for (int c = 0; c < 10 && sb.size() > 0; c++) begin
      if (out_valid) begin
        e = sb.pop_front();
        vectors++;
        if (out_result !== e.res || out_wr_reg !== e.wr) begin
          miscompares++;
          $display("FAIL rand_drain: got %h r%0d expected %h r%0d", out_result, out_wr_reg, e.res, e.wr);
        end
      end
      tick();
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL rand_lost: %0d results never emerged expected 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_op(2'b00, 16'h1357 + 16'(i), 16'h0, 4'd4, 1'b1, 3'd0, 3'd7);
      tick();
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++; $display("FAIL arst_pre: out_valid got %b expected 1", out_valid);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_result !== 16'h0000 || out_wr_reg !== 3'd0) begin
      miscompares++;
      $display("FAIL arst_immediate: got v=%b %h r%0d expected v=0 0000 r0",
               out_valid, out_result, out_wr_reg);
    end
    idle();
    tick();
    rst = 1'b0;
    #1;
    drive_op(2'b10, 16'h00AB, 16'h0, 4'd4, 1'b1, 3'd0, 3'd2);
    tick();
    idle();
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++; $display("FAIL arst_no_stale: out_valid got %b expected 0", out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out_result !== 16'hB00A || out_wr_reg !== 3'd2) begin
      miscompares++;
      $display("FAIL arst_first_op: got v=%b %h r%0d expected v=1 b00a r2",
               out_valid, out_result, out_wr_reg);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_op_sweep();
    test_backpressure();
    test_flush();
    test_forward();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
